// File: rtl/timing_sequence_generator.sv
`default_nettype none
// ============================================================================
// Module      : timing_sequence_generator
// Description : Control-unit state counter with one-hot T decode, clear, load,
//               programmable wrap point, single-step advance and wrap pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module timing_sequence_generator #(
  parameter int CNT_W   = 4,
  parameter int RST_VAL = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    load,
  input  logic [CNT_W-1:0]        load_val,
  input  logic                    hold,
  input  logic                    step,
  input  logic [CNT_W-1:0]        last_state,
  output logic [CNT_W-1:0]        sc,
  output logic [(2**CNT_W)-1:0]   t,
  output logic                    wrap
);

  localparam int NUM_T = 2**CNT_W;
  localparam logic [CNT_W-1:0] C_RST_SC = CNT_W'(RST_VAL);

  logic             r_step_q;
  logic             w_step_event;
  logic             w_is_wrap;
  logic [CNT_W-1:0] w_next;

  assign w_step_event = step & ~r_step_q;

  // >= rather than == so an out-of-range count returns straight to 0
  assign w_is_wrap = (sc >= last_state);
  assign w_next    = w_is_wrap ? '0 : sc + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sc       <= C_RST_SC;
      wrap     <= 1'b0;
      r_step_q <= 1'b0;
    end else begin
      r_step_q <= step;
      if (clr) begin
        sc   <= '0;
        wrap <= 1'b0;
      end else if (load) begin
        sc   <= load_val;
        wrap <= 1'b0;
      end else if (hold) begin
        if (w_step_event) begin
          sc   <= w_next;
          wrap <= w_is_wrap;
        end else begin
          wrap <= 1'b0;
        end
      end else begin
        sc   <= w_next;
        wrap <= w_is_wrap;
      end
    end
  end

  for (genvar i = 0; i < NUM_T; i++) begin : g_decode
    assign t[i] = (sc == CNT_W'(i));
  end

endmodule
`default_nettype wire

// File: tb/tb_timing_sequence_generator.sv
`default_nettype none
// ============================================================================
// Module      : tb_timing_sequence_generator
// Description : Table-driven and randomized checks against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_timing_sequence_generator;

  localparam int CNT_W = 4;
  localparam int NUM_T = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             clr, load, hold, step;
  logic [CNT_W-1:0] load_val, last_state;
  logic [CNT_W-1:0] sc;
  logic [NUM_T-1:0] t;
  logic             wrap;

  int checks = 0;
  int errors = 0;

  // reference model state
  int   m_sc;
  logic m_wrap;
  logic m_step_prev;

  typedef struct {
    logic       clr;
    logic       load;
    logic [3:0] lv;
    logic       hold;
    logic       step;
    logic [3:0] ls;
    int         sc;
    logic       wrap;
  } vec_t;

  vec_t tbl[$];

  timing_sequence_generator #(.CNT_W(CNT_W), .RST_VAL(0)) dut (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val),
    .hold(hold), .step(step), .last_state(last_state),
    .sc(sc), .t(t), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (time %0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input int exp_sc, input logic exp_wrap);
    logic [NUM_T-1:0] oh;
    oh = NUM_T'(1) << exp_sc;
    chk({tag, ".sc"}, int'(sc), exp_sc);
    chk({tag, ".wrap"}, int'(wrap), int'(exp_wrap));
    chk({tag, ".t"}, int'(t), int'(oh));
  endtask

  task automatic add(input logic c, input logic l, input int lv, input logic h,
                     input logic s, input int ls, input int esc, input logic ew);
    vec_t v;
    v.clr = c; v.load = l; v.lv = 4'(lv); v.hold = h; v.step = s;
    v.ls = 4'(ls); v.sc = esc; v.wrap = ew;
    tbl.push_back(v);
  endtask

  // spec rules applied to the inputs present at the edge
  task automatic model_edge();
    logic ev;
    int   nx;
    logic iw;
    ev = step && !m_step_prev;
    iw = (m_sc >= int'(last_state));
    nx = iw ? 0 : m_sc + 1;
    if (clr) begin
      m_sc = 0; m_wrap = 1'b0;
    end else if (load) begin
      m_sc = int'(load_val); m_wrap = 1'b0;
    end else if (hold) begin
      if (ev) begin m_sc = nx; m_wrap = iw; end
      else m_wrap = 1'b0;
    end else begin
      m_sc = nx; m_wrap = iw;
    end
    m_step_prev = step;
  endtask

  task automatic edge_step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    rst = 1'b1; clr = 0; load = 0; hold = 0; step = 0;
    load_val = '0; last_state = 4'd3;
    m_sc = 0; m_wrap = 1'b0; m_step_prev = 1'b0;
    #3;
    chk_all("reset", 0, 1'b0);
    #9 rst = 1'b0;

    // free run, last_state = 3
    for (int i = 0; i < 9; i++) add(0,0,0,0,0,3, (i+1)%4, ((i+1)%4)==0);
    // last_state = 5 from sc=1
    add(0,0,0,0,0,5,2,0); add(0,0,0,0,0,5,3,0); add(0,0,0,0,0,5,4,0);
    add(0,0,0,0,0,5,5,0); add(0,0,0,0,0,5,0,1); add(0,0,0,0,0,5,1,0);
    add(0,0,0,0,0,5,2,0); add(0,0,0,0,0,5,3,0); add(0,0,0,0,0,5,4,0);
    add(0,0,0,0,0,5,5,0); add(0,0,0,0,0,5,0,1);
    // load beyond wrap point, then straight back to 0
    add(0,1,9,0,0,5,9,0); add(0,0,0,0,0,5,0,1);
    add(0,0,0,0,0,5,1,0); add(0,0,0,0,0,5,2,0);
    // single-step while held, last_state = 3
    add(0,0,0,1,1,3,3,0); add(0,0,0,1,1,3,3,0); add(0,0,0,1,1,3,3,0);
    add(0,0,0,1,0,3,3,0); add(0,0,0,1,0,3,3,0); add(0,0,0,1,1,3,0,1);
    add(0,0,0,1,1,3,0,0);
    // hold raised while step already high: no advance
    add(0,0,0,0,1,3,1,0); add(0,0,0,1,1,3,1,0); add(0,0,0,1,0,3,1,0);
    // clear beats load at the wrap point
    add(0,0,0,0,0,3,2,0); add(0,0,0,0,0,3,3,0);
    add(1,1,7,0,0,3,0,0); add(0,1,2,0,0,3,2,0);
    add(0,0,0,0,0,3,3,0); add(0,0,0,0,0,3,0,1);
    // last_state = 0: stuck at 0, wrap every cycle
    for (int i = 0; i < 4; i++) add(0,0,0,0,0,0,0,1);
    // reach sc=4 for the async reset test
    for (int i = 1; i <= 4; i++) add(0,0,0,0,0,5,i,0);

    foreach (tbl[k]) begin
      clr = tbl[k].clr; load = tbl[k].load; load_val = tbl[k].lv;
      hold = tbl[k].hold; step = tbl[k].step; last_state = tbl[k].ls;
      edge_step();
      chk_all($sformatf("vec%0d", k), tbl[k].sc, tbl[k].wrap);
    end

    // asynchronous reset between edges
    clr = 0; load = 0; hold = 0; step = 0; last_state = 4'd5;
    #2 rst = 1'b1;
    #1 chk_all("async_rst", 0, 1'b0);
    #2 rst = 1'b0;
    m_sc = 0; m_wrap = 1'b0; m_step_prev = 1'b0;
    edge_step();
    chk_all("post_rst", 1, 1'b0);
    chk_all("post_rst_model", m_sc, m_wrap);

    // randomized against the model
    for (int n = 0; n < 400; n++) begin
      clr  = ($urandom_range(15) == 0);
      load = ($urandom_range(7) == 0);
      load_val = 4'($urandom);
      hold = $urandom_range(1);
      step = $urandom_range(1);
      if ($urandom_range(7) == 0) begin
        case ($urandom_range(3))
          0: last_state = 4'd0;
          1: last_state = 4'd15;
          default: last_state = 4'($urandom);
        endcase
      end
      edge_step();
      chk_all("rand", m_sc, m_wrap);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/timing_sequence_generator.md
Name: timing_sequence_generator

Overview:
- Parametrised timing/sequence counter for the control unit.
- Produces a binary state count `sc` and a one-hot decoded timing bus `t` (T0..Tn-1) that the instruction-cycle decoder consumes.
- Adds four things the fixed 2-bit counter does not have:
  - synchronous clear (SC <- 0);
  - parallel load;
  - a runtime-programmable wrap point;
  - single-step advance while frozen, plus a wrap pulse.

Parameters:
- CNT_W, 4, width of the state counter; number of timing outputs is NUM_T = 2**CNT_W (local, derived).
- RST_VAL, 0, value loaded into `sc` on reset; must be < 2**CNT_W.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- clr  input  1  synchronous clear: `sc` <- 0 on the next edge (control unit "SC <- 0").
- load  input  1  synchronous parallel load of `load_val`.
- load_val  input  CNT_W  value for load.
- hold  input  1  freeze; `sc` keeps its value unless a step event occurs.
- step  input  1  single-step request; only its rising edge is used, and only while `hold` = 1.
- last_state  input  CNT_W  runtime wrap point: the state after `last_state` is 0.
- sc  output  CNT_W  current state count.
- t  output  NUM_T  one-hot decode of `sc`.
- wrap  output  1  registered one-cycle pulse marking a wrap to 0.

Behaviour:
- Reset (rst = 1, asynchronous, takes effect immediately):
  - `sc` = RST_VAL; `wrap` = 0; internal step register `step_q` = 0.
  - `t` follows `sc`, so `t` = one-hot(RST_VAL).
  - Reset asserted mid-sequence aborts the sequence. After deassertion, the first edge evaluates normally.
- Step edge detection:
  - `step_q` <- `step` every edge.
  - step_event = `step` & ~`step_q`.
- Advance (computed combinationally):
  - If `sc` >= `last_state`, next = 0 and is_wrap = 1.
  - Otherwise next = `sc` + 1 and is_wrap = 0.
  - The >= comparison covers `sc` above `last_state` after a load or after `last_state` is lowered: the count goes straight to 0. It never runs up to the top and wraps modulo 2**CNT_W.
- Per-edge priority (highest first):
  1. `clr`: `sc` <- 0; `wrap` <- 0.
  2. `load`: `sc` <- `load_val` (no range check); `wrap` <- 0.
  3. `hold` = 1:
     - if step_event, `sc` <- next and `wrap` <- is_wrap;
     - otherwise `sc` unchanged and `wrap` <- 0.
  4. Otherwise: `sc` <- next; `wrap` <- is_wrap.
- `wrap` timing:
  - Registered, so it is high in the same cycle `sc` first shows 0 after a wrap.
  - Clear, load and reset never raise `wrap`.
- `last_state` = 0: `sc` stays 0 and `wrap` is high on every advancing cycle.
- `last_state` = 2**CNT_W-1: plain modulo-NUM_T counting.
- `t` decode:
  - Combinational from `sc`: t[i] = (sc == i).
  - Exactly one bit is high at all times, including during reset.
- `step` while `hold` = 0:
  - Ignored, but `step_q` still tracks it.
  - So `step` already high when `hold` rises does not generate an event.
- `load_val` or `last_state` changing mid-cycle is sampled only at the edge.
- No combinational path from any input to `sc`, `wrap` or `t`, except `rst` (asynchronous) and `sc` -> `t` decode.

Test Plan:
- Reset, then free-run with CNT_W=2 and `last_state`=3 for 9 edges -> `sc` = 0,1,2,3,0,1,2,3,0,1; `wrap` high exactly in the cycles where `sc` returns to 0; `t` = 0001,0010,0100,1000,...
- CNT_W=4, `last_state`=5, free-run -> `sc` cycles 0..5 only; `wrap` every 6th cycle. Then drive `load`=1 with `load_val`=9 for one edge -> next edge `sc`=0 with `wrap`=1 (>= rule).
- `hold`=1 at `sc`=2; drive `step` high for 3 cycles, low for 2, high for 1 -> `sc` goes 2->3 on the first rising edge of `step`, then 3->0 with `wrap`=1 on the second; stays frozen otherwise. Raise `hold` while `step` is already high -> no advance.
- `clr` and `load` asserted together with `hold`=0 at `sc`=3, `last_state`=3 -> `sc`=0 and `wrap`=0 (clear wins, no wrap pulse). Then `load` alone with `load_val`=2 -> `sc`=2.
- Assert `rst` asynchronously between edges at `sc`=4 (RST_VAL=0) -> `sc`=0, `t`=one-hot(0) and `wrap`=0 immediately, before any clock edge. After release, counting resumes at 1 on the first edge.
- `last_state`=0 free-run -> `sc` held at 0 and `wrap` high continuously; check `t`[0]=1 throughout.
